// File: rtl/rx_cnt_pkg.sv
// Shared types and constants for the rx_mod_counter family of event counters.
// Optional compare feature of rx_mod_counter is enabled with the RX_CNT_CMP_EN macro.
package rx_cnt_pkg;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_UP,
    OP_DOWN,
    OP_LOAD,
    OP_CLEAR
  } cnt_op_e;

  localparam int CNT_MODE_WRAP = 0;
  localparam int CNT_MODE_SAT  = 1;

endpackage

// File: rtl/rx_cnt_next.sv
// Combinational next-count unit: applies one decoded operation to the current count
// and flags steps that hit a bound (wrap or blocked saturation).
module rx_cnt_next
  import rx_cnt_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int SATURATE  = CNT_MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] next_count,
  output logic             bound_hit
);

  // One extra bit keeps the bound comparison honest when MAX_VAL < 2**WIDTH-1.
  localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] load_ext;

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_val};

  always_comb begin
    next_count = count;
    bound_hit  = 1'b0;
    case (op)
      OP_CLEAR: next_count = WIDTH'(RESET_VAL);
      OP_LOAD:  next_count = (load_ext > MAX_EXT) ? WIDTH'(MAX_EXT) : load_val;
      OP_UP: begin
        if (count_ext >= MAX_EXT) begin
          bound_hit  = 1'b1;
          next_count = (SATURATE == CNT_MODE_SAT) ? count : '0;
        end else begin
          next_count = WIDTH'(count_ext + (WIDTH+1)'(1));
        end
      end
      OP_DOWN: begin
        if (count_ext == '0) begin
          bound_hit  = 1'b1;
          next_count = (SATURATE == CNT_MODE_SAT) ? count : WIDTH'(MAX_EXT);
        end else begin
          next_count = WIDTH'(count_ext - (WIDTH+1)'(1));
        end
      end
      default: next_count = count;
    endcase
  end

endmodule

// File: rtl/rx_mod_counter.sv
// Parametrised up/down modulus counter with wrap/saturate, load, terminal-count pulse and sticky ovf.
// Define RX_CNT_CMP_EN to add the cmp_val/cmp_hit compare-match pulse.
module rx_mod_counter
  import rx_cnt_pkg::*;
#(
  parameter int WIDTH     = 3,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int SATURATE  = CNT_MODE_WRAP,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             incr,
  input  logic             decr,
  input  logic             ovf_clr,
`ifdef RX_CNT_CMP_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             cmp_hit,
`endif
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "rx_mod_counter: WIDTH must be >= 1");
  end
  if (MAX_VAL < 0 || MAX_VAL > (1 << WIDTH) - 1) begin : g_bad_max
    $fatal(1, "rx_mod_counter: MAX_VAL out of range");
  end
  if (RESET_VAL < 0 || RESET_VAL > MAX_VAL) begin : g_bad_reset
    $fatal(1, "rx_mod_counter: RESET_VAL out of range");
  end

  cnt_op_e          op;
  logic [WIDTH-1:0] next_count;
  logic             bound_hit;

  always_comb begin
    op = OP_HOLD;
    if (clear)              op = OP_CLEAR;
    else if (load)          op = OP_LOAD;
    else if (incr ^ decr)   op = incr ? OP_UP : OP_DOWN;
  end

  rx_cnt_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE),
    .RESET_VAL(RESET_VAL)
  ) u_next (
    .op        (op),
    .count     (count),
    .load_val  (load_val),
    .next_count(next_count),
    .bound_hit (bound_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= WIDTH'(RESET_VAL);
      tc    <= 1'b0;
      ovf   <= 1'b0;
`ifdef RX_CNT_CMP_EN
      cmp_hit <= 1'b0;
`endif
    end else begin
      count <= next_count;
      tc    <= bound_hit;
      // A new overflow beats ovf_clr; clear beats everything.
      if (op == OP_CLEAR)  ovf <= 1'b0;
      else if (bound_hit)  ovf <= 1'b1;
      else if (ovf_clr)    ovf <= 1'b0;
`ifdef RX_CNT_CMP_EN
      cmp_hit <= (next_count == cmp_val) &&
                 ((next_count != count) || (op == OP_LOAD) || (op == OP_CLEAR));
`endif
    end
  end

  assign at_max  = (count == WIDTH'(MAX_VAL));
  assign at_zero = (count == '0);

endmodule
